dose_scheduler: RTL and testbench

Medication-dose scheduler for the patient-monitor clock design. Consumes the 4-bit state code and 24-bit BCD time produced by the front-panel control block, and the dose interval returned by the patient ROM. Keeps the running 12-hour BCD wall clock and counts down to each dose. Raises a dose alarm, waits for a nurse acknowledge, and tallies missed doses.

---
 rtl/dose_pkg.sv | 25 ++
 rtl/dose_scheduler_if.sv | 26 ++
 rtl/bcd_clock_12h.sv | 65 ++++++
 rtl/dose_scheduler.sv | 145 ++++++++++++++
 tb/tb_dose_scheduler.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dose_pkg.sv
// Shared state codes, FSM encoding and BCD types for the medication-dose scheduler.
package dose_pkg;

  localparam logic [3:0] ST_RESET = 4'd0;
  localparam logic [3:0] ST_SET   = 4'd1;
  localparam logic [3:0] ST_LOAD  = 4'd2;
  localparam logic [3:0] ST_START = 4'd3;
  localparam logic [3:0] ST_IDLE  = 4'd4;

  localparam int SECS_PER_MIN = 60;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ALARM
  } fsmStateT;

  typedef logic [3:0] bcdDigitT;

  // Largest interval (255 min) gives 15300 s, which still fits the 14-bit countdown.
  function automatic logic [13:0] minsToSecs(logic [7:0] mins);
    return 14'({6'd0, mins} * 14'(SECS_PER_MIN));
  endfunction

endpackage

// File: rtl/dose_scheduler_if.sv
// Control, ROM and nurse inputs plus the status outputs of the dose scheduler.
interface dose_scheduler_if;

  logic [3:0]  state;
  logic [23:0] setTime;
  logic        romValid;
  logic [7:0]  romInterval;
  logic        ack;

  logic [23:0] curTime;
  logic [13:0] secsToDose;
  logic        running;
  logic        alarm;
  logic [3:0]  missedCount;

  modport master (
    output state, setTime, romValid, romInterval, ack,
    input  curTime, secsToDose, running, alarm, missedCount
  );

  modport slave (
    input  state, setTime, romValid, romInterval, ack,
    output curTime, secsToDose, running, alarm, missedCount
  );

endinterface

// File: rtl/bcd_clock_12h.sv
// 12-hour BCD wall clock HH:MM:SS with synchronous clear, parallel load and
// a per-second advance strobe.
module bcd_clock_12h
  import dose_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        clear,
  input  logic        load,
  input  logic [23:0] loadValue,
  input  logic        enable,
  input  logic        tick,
  output logic [23:0] count
);

  bcdDigitT    hT, hU, mT, mU, sT, sU;
  logic [23:0] nextCount;

  assign {hT, hU, mT, mU, sT, sU} = count;

  always_comb begin
    nextCount = count;
    if (sU != 4'd9) begin
      nextCount[3:0] = sU + 4'd1;
    end else begin
      nextCount[3:0] = 4'd0;
      if (sT != 4'd5) begin
        nextCount[7:4] = sT + 4'd1;
      end else begin
        nextCount[7:4] = 4'd0;
        if (mU != 4'd9) begin
          nextCount[11:8] = mU + 4'd1;
        end else begin
          nextCount[11:8] = 4'd0;
          if (mT != 4'd5) begin
            nextCount[15:12] = mT + 4'd1;
          end else begin
            nextCount[15:12] = 4'd0;
            if ({hT, hU} == 8'h12)
              nextCount[23:16] = 8'h01;
            else if (hU == 4'd9)
              nextCount[23:16] = {hT + 4'd1, 4'd0};
            else
              nextCount[23:16] = {hT, hU + 4'd1};
          end
        end
      end
    end
    // Hour 00 only exists straight after reset; the first tick snaps it to 01.
    if ({hT, hU} == 8'h00)
      nextCount[23:16] = 8'h01;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (load)
      count <= loadValue;
    else if (enable && tick)
      count <= nextCount;
  end

endmodule

// File: rtl/dose_scheduler.sv
// Dose scheduler: second prescaler, dose countdown, alarm/acknowledge FSM and
// missed-dose tally. Missed counting is built only with DOSE_MISSED_CNT_EN.
//
//   state | meaning
//   IDLE  | clock stopped; accepts time set, interval load and start
//   RUN   | clock and dose countdown running, no alarm pending
//   ALARM | running with a dose alarm waiting for a nurse acknowledge
module dose_scheduler
  import dose_pkg::*;
#(
  parameter int TICKS_PER_SEC   = 50_000_000,
  parameter int ALARM_TIMEOUT_S = 300
) (
  input logic             clk,
  input logic             resetN,
  dose_scheduler_if.slave bus
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = (ALARM_TIMEOUT_S > 0) ? $clog2(ALARM_TIMEOUT_S + 1) : 1;

`ifdef DOSE_MISSED_CNT_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  fsmStateT      fsm;
  logic [PW-1:0] prescaler;
  logic [13:0]   secsQ;
  logic [7:0]    interval;
  logic [AW-1:0] alarmTimer;
  logic [3:0]    missedQ;
  logic          runningQ;
  logic          alarmQ;
  logic          ackPrev;
  logic [23:0]   curTimeQ;

  logic          termCount;
  logic          tick;
  logic          countDown;
  logic          doseDue;
  logic          ackRise;
  logic          timerExpired;
  logic [13:0]   reloadSecs;
  logic [3:0]    missedNext;

  assign termCount    = (prescaler == PW'(TICKS_PER_SEC - 1));
  assign tick         = (fsm != IDLE) && termCount;
  assign countDown    = tick && (interval != 8'd0) && (secsQ != 14'd0);
  assign doseDue      = countDown && (secsQ == 14'd1);
  assign ackRise      = bus.ack && !ackPrev;
  assign timerExpired = tick && (alarmTimer <= AW'(1));
  assign reloadSecs   = minsToSecs(interval);
  assign missedNext   = (MISS_EN && missedQ != 4'hF) ? missedQ + 4'd1 : missedQ;

  bcd_clock_12h uClock (
    .clk       (clk),
    .resetN    (resetN),
    .clear     (bus.state == ST_RESET),
    .load      ((fsm == IDLE) && (bus.state == ST_SET)),
    .loadValue (bus.setTime),
    .enable    (fsm != IDLE),
    .tick      (termCount),
    .count     (curTimeQ)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fsm        <= IDLE;
      prescaler  <= '0;
      secsQ      <= '0;
      interval   <= '0;
      alarmTimer <= '0;
      missedQ    <= '0;
      runningQ   <= 1'b0;
      alarmQ     <= 1'b0;
      ackPrev    <= 1'b0;
    end else begin
      ackPrev <= bus.ack;
      if (bus.state == ST_RESET) begin
        fsm        <= IDLE;
        prescaler  <= '0;
        secsQ      <= '0;
        interval   <= '0;
        alarmTimer <= '0;
        missedQ    <= '0;
        runningQ   <= 1'b0;
        alarmQ     <= 1'b0;
      end else begin
        if (fsm != IDLE) begin
          prescaler <= termCount ? '0 : prescaler + PW'(1);
          // A new interval only lands in the countdown at its next reload.
          if (bus.romValid)
            interval <= bus.romInterval;
          if (countDown)
            secsQ <= doseDue ? reloadSecs : secsQ - 14'd1;
        end
        case (fsm)
          IDLE: begin
            if (bus.state == ST_LOAD && bus.romValid)
              interval <= bus.romInterval;
            if (bus.state == ST_START) begin
              fsm       <= RUN;
              runningQ  <= 1'b1;
              secsQ     <= reloadSecs;
              prescaler <= '0;
            end
          end
          RUN: begin
            if (doseDue) begin
              fsm        <= ALARM;
              alarmQ     <= 1'b1;
              alarmTimer <= AW'(ALARM_TIMEOUT_S);
            end
          end
          ALARM: begin
            if (doseDue) begin
              if (!ackRise)
                missedQ <= missedNext;
              alarmTimer <= AW'(ALARM_TIMEOUT_S);
            end else if (ackRise) begin
              alarmQ <= 1'b0;
              fsm    <= RUN;
            end else if (timerExpired) begin
              missedQ <= missedNext;
              alarmQ  <= 1'b0;
              fsm     <= RUN;
            end else if (tick) begin
              alarmTimer <= alarmTimer - AW'(1);
            end
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end

  assign bus.curTime     = curTimeQ;
  assign bus.secsToDose  = secsQ;
  assign bus.running     = runningQ;
  assign bus.alarm       = alarmQ;
  assign bus.missedCount = MISS_EN ? missedQ : 4'd0;

endmodule

// File: tb/tb_dose_scheduler.sv
// Bench for dose_scheduler: wall-clock/alarm reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dose_scheduler;

  localparam int TPS = 4;
  localparam int TO  = 5;

`ifdef DOSE_MISSED_CNT_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  logic clk    = 1'b0;
  logic resetN = 1'b1;

  dose_scheduler_if ifc ();

  dose_scheduler #(.TICKS_PER_SEC(TPS), .ALARM_TIMEOUT_S(TO)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: wall clock as plain h/m/s integers, everything else as counters.
  int mHh = 0, mMm = 0, mSs = 0;
  int mPre = 0, mSecs = 0, mInterval = 0, mLeft = 0, mMiss = 0;
  bit mRun = 0, mAlarm = 0, mAckPrev = 0;

  function automatic logic [23:0] bcd6(int h, int m, int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] randTime();
    return bcd6($urandom_range(0, 12), $urandom_range(0, 59), $urandom_range(0, 59));
  endfunction

  task automatic mClear();
    mHh = 0; mMm = 0; mSs = 0;
    mPre = 0; mSecs = 0; mInterval = 0; mLeft = 0; mMiss = 0;
    mRun = 0; mAlarm = 0;
  endtask

  task automatic mStep();
    bit tick, due, rise;
    rise = ifc.ack && !mAckPrev;
    mAckPrev = ifc.ack;
    if (ifc.state == 4'd0) begin
      mClear();
      return;
    end
    if (!mRun) begin
      if (ifc.state == 4'd1) begin
        mHh = int'(ifc.setTime[23:20]) * 10 + int'(ifc.setTime[19:16]);
        mMm = int'(ifc.setTime[15:12]) * 10 + int'(ifc.setTime[11:8]);
        mSs = int'(ifc.setTime[7:4]) * 10 + int'(ifc.setTime[3:0]);
      end
      if (ifc.state == 4'd2 && ifc.romValid) mInterval = int'(ifc.romInterval);
      if (ifc.state == 4'd3) begin
        mRun = 1; mSecs = mInterval * 60; mPre = 0;
      end
      return;
    end
    tick = (mPre == TPS - 1);
    mPre = (mPre + 1) % TPS;
    due  = 0;
    if (tick) begin
      mSs++;
      if (mSs == 60) begin
        mSs = 0; mMm++;
        if (mMm == 60) begin
          mMm = 0; mHh = (mHh >= 12) ? 1 : mHh + 1;
        end
      end
      if (mHh == 0) mHh = 1;
      if (mInterval != 0 && mSecs > 0) begin
        mSecs--;
        if (mSecs == 0) begin
          due = 1; mSecs = mInterval * 60;
        end
      end
    end
    if (ifc.romValid) mInterval = int'(ifc.romInterval);
    if (!mAlarm) begin
      if (due) begin mAlarm = 1; mLeft = TO; end
    end else if (due) begin
      if (!rise) mMiss++;
      mLeft = TO;
    end else if (rise) begin
      mAlarm = 0;
    end else if (tick) begin
      mLeft--;
      if (mLeft == 0) begin mMiss++; mAlarm = 0; end
    end
  endtask

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mClear();
      mAckPrev = 0;
    end else begin
      mStep();
    end
  end

  always @(negedge clk) begin
    logic [23:0] eT;
    logic [13:0] eS;
    logic [3:0]  eM;
    cycle++;
    eT = bcd6(mHh, mMm, mSs);
    eS = 14'(mSecs);
    eM = MISS_EN ? 4'((mMiss > 15) ? 15 : mMiss) : 4'd0;
    checks++;
    if (ifc.curTime !== eT || ifc.secsToDose !== eS || ifc.running !== mRun ||
        ifc.alarm !== mAlarm || ifc.missedCount !== eM) begin
      errors++;
      if (errors <= 20)
        $display("FAIL cycle%0d outputs: got time=%h secs=%0d run=%0b alarm=%0b miss=%0d, want time=%h secs=%0d run=%0b alarm=%0b miss=%0d",
                 cycle, ifc.curTime, ifc.secsToDose, ifc.running, ifc.alarm, ifc.missedCount,
                 eT, eS, mRun, mAlarm, eM);
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic loadAndStart(logic [7:0] mins);
    ifc.state = 4'd0; step(1);
    ifc.state = 4'd2; ifc.romValid = 1'b1; ifc.romInterval = mins; step(1);
    ifc.romValid = 1'b0;
    ifc.state = 4'd3; step(1);
    ifc.state = 4'd4;
  endtask

  function automatic logic [63:0] allOut();
    return {20'd0, ifc.curTime, ifc.secsToDose, ifc.running, ifc.alarm, ifc.missedCount};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    ifc.state = 4'd4; ifc.setTime = '0; ifc.romValid = 1'b0; ifc.romInterval = '0; ifc.ack = 1'b0;
    #1 resetN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ifc.state = 4'($urandom_range(0, 4)); ifc.setTime = 24'($urandom);
      ifc.romValid = 1'($urandom); ifc.romInterval = 8'($urandom); ifc.ack = 1'($urandom);
      step(1);
    end
    chk("reset_outputs", allOut(), 64'd0);
    ifc.state = 4'd4; ifc.romValid = 1'b0; ifc.ack = 1'b0;
    resetN = 1'b1;
    step(4);
    chk("idle_outputs", allOut(), 64'd0);

    // Time set then wrap through 12:59:59
    ifc.state = 4'd1; ifc.setTime = 24'h125958; step(2);
    ifc.state = 4'd3; step(1);
    chk("start_running", 64'(ifc.running), 64'd1);
    ifc.state = 4'd4; step(8);
    chk("time_wrap", 64'(ifc.curTime), 64'h010000);

    // One-minute interval, acknowledged
    loadAndStart(8'd1);
    chk("secs_at_start", 64'(ifc.secsToDose), 64'd60);
    step(239);
    chk("no_alarm_yet", 64'(ifc.alarm), 64'd0);
    step(1);
    chk("alarm_rise", 64'(ifc.alarm), 64'd1);
    chk("secs_reload", 64'(ifc.secsToDose), 64'd60);
    ifc.ack = 1'b1; step(1);
    chk("ack_clears", 64'(ifc.alarm), 64'd0);
    chk("ack_no_miss", 64'(ifc.missedCount), 64'd0);
    ifc.ack = 1'b0;

    // Never acknowledged: timeouts and saturation
    loadAndStart(8'd1);
    step(240);
    chk("alarm_rise2", 64'(ifc.alarm), 64'd1);
    step(19);
    chk("alarm_held", 64'(ifc.alarm), 64'd1);
    step(1);
    chk("alarm_timeout", 64'(ifc.alarm), 64'd0);
    chk("miss_one", 64'(ifc.missedCount), MISS_EN ? 64'd1 : 64'd0);
    step(3600);
    chk("miss_saturate", 64'(ifc.missedCount), MISS_EN ? 64'd15 : 64'd0);
    step(220);
    chk("alarm_rise17", 64'(ifc.alarm), 64'd1);
    ifc.state = 4'd0; step(1);
    chk("soft_reset", allOut(), 64'd0);
    ifc.state = 4'd4; step(2);

    // Interval zero: never alarms
    loadAndStart(8'd0);
    step(4000);
    chk("zero_int_time", 64'(ifc.curTime), 64'h011640);
    chk("zero_int_secs", 64'(ifc.secsToDose), 64'd0);
    chk("zero_int_alarm", 64'(ifc.alarm), 64'd0);

    // Asynchronous reset mid-alarm
    loadAndStart(8'd1);
    step(240);
    chk("alarm_before_areset", 64'(ifc.alarm), 64'd1);
    @(posedge clk); #2;
    resetN = 1'b0; #1;
    chk("async_reset", allOut(), 64'd0);
    step(1);
    resetN = 1'b1;
    step(2);

    // Randomized traffic
    for (int r = 0; r < 5; r++) begin
      ifc.state = 4'd0; step(1);
      ifc.state = 4'd1; ifc.setTime = randTime(); step(1);
      ifc.state = 4'd2; ifc.romValid = 1'b1; ifc.romInterval = 8'($urandom_range(1, 3)); step(1);
      ifc.romValid = 1'b0;
      ifc.state = 4'd3; step(1);
      for (int c = 0; c < 3000; c++) begin
        ifc.romValid    = ($urandom_range(0, 199) == 0);
        ifc.romInterval = 8'($urandom_range(0, 3));
        if ($urandom_range(0, 29) == 0) ifc.ack = ~ifc.ack;
        k = $urandom_range(0, 999);
        ifc.state   = (k < 3) ? 4'd0 : (k < 40) ? 4'($urandom_range(1, 3)) : 4'd4;
        ifc.setTime = randTime();
        if ($urandom_range(0, 1999) == 0) begin
          resetN = 1'b0; step(2); resetN = 1'b1;
        end
        step(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
